// File: rtl/trap_initiator.sv
// Trap source: machine timer/software-interrupt registers plus exception/interrupt arbitration.
// Latency: exception -> trap_en next cycle; interrupt -> drain until pipe_empty, then trap_en next cycle.
// Backpressure: stall_fetch holds fetch while an interrupt drains; timer writes are accepted in every state.
`timescale 1ns/1ps
module trap_initiator #(
   parameter int REG_WIDTH = 64,
   parameter int TIMER_DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tmr_wr_en,
   input  logic [1:0]           tmr_wr_sel,
   input  logic [REG_WIDTH-1:0] tmr_wr_data,
   output logic [REG_WIDTH-1:0] mtime,
   output logic                 mip_mtip,
   output logic                 mip_msip,
   input  logic                 mstatus_mie,
   input  logic                 mie_mtie,
   input  logic                 mie_msie,
   input  logic [1:0]           curr_priv,
   input  logic                 exc_valid,
   input  logic [5:0]           exc_cause,
   input  logic [REG_WIDTH-1:0] exc_pc,
   input  logic [REG_WIDTH-1:0] exc_tval,
   input  logic [REG_WIDTH-1:0] commit_pc,
   input  logic                 pipe_empty,
   output logic                 stall_fetch,
   output logic                 trap_en,
   output logic [REG_WIDTH-1:0] trap_cause,
   output logic [REG_WIDTH-1:0] trap_pc,
   output logic [REG_WIDTH-1:0] trap_mtval
);

   // Prescaler is at least one bit wide so TIMER_DIV=1 still elaborates cleanly.
   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FIRE  = 2'd2
   } state_t;

   state_t               state;
   logic [PW-1:0]        prescaler;
   logic [REG_WIDTH-1:0] mtimecmp;
   logic                 msip;
   logic [REG_WIDTH-1:0] irq_cause_lat;

   logic                 int_en;
   logic                 msi;
   logic                 mti;
   logic                 pre_wrap;
   logic [REG_WIDTH-1:0] irq_cause;
   logic [REG_WIDTH-1:0] exc_cause_ext;

   assign pre_wrap      = (prescaler == PRE_MAX);
   assign mip_mtip      = (mtime >= mtimecmp);
   assign mip_msip      = msip;
   assign int_en        = (curr_priv != 2'b11) | mstatus_mie;
   assign msi           = msip & mie_msie;
   assign mti           = mip_mtip & mie_mtie;
   // Software interrupt (code 3) outranks timer interrupt (code 7).
   assign irq_cause     = {1'b1, (REG_WIDTH-1)'(msi ? 3 : 7)};
   assign exc_cause_ext = {{(REG_WIDTH-6){1'b0}}, exc_cause};

   // Timer block: prescaled mtime counter, compare register and software-interrupt bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         msip      <= 1'b0;
         prescaler <= '0;
      end else begin
         prescaler <= pre_wrap ? '0 : prescaler + PW'(1);
         // A software write to mtime wins over the tick in the same cycle.
         if (tmr_wr_en && tmr_wr_sel == 2'd2)
            mtime <= tmr_wr_data;
         else if (pre_wrap)
            mtime <= mtime + REG_WIDTH'(1);
         if (tmr_wr_en && tmr_wr_sel == 2'd0)
            mtimecmp <= tmr_wr_data;
         if (tmr_wr_en && tmr_wr_sel == 2'd1)
            msip <= tmr_wr_data[0];
      end
   end

   // Trap FSM: outputs are registered so trap_en and its payload appear together in FIRE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         irq_cause_lat <= '0;
         stall_fetch   <= 1'b0;
         trap_en       <= 1'b0;
         trap_cause    <= '0;
         trap_pc       <= '0;
         trap_mtval    <= '0;
      end else begin
         stall_fetch <= 1'b0;
         trap_en     <= 1'b0;
         trap_cause  <= '0;
         trap_pc     <= '0;
         trap_mtval  <= '0;
         case (state)
            IDLE: begin
               if (exc_valid) begin
                  // Exceptions beat a simultaneous interrupt.
                  state      <= FIRE;
                  trap_en    <= 1'b1;
                  trap_cause <= exc_cause_ext;
                  trap_pc    <= exc_pc;
                  trap_mtval <= exc_tval;
               end else if (int_en && (msi || mti)) begin
                  state         <= DRAIN;
                  irq_cause_lat <= irq_cause;
                  stall_fetch   <= 1'b1;
               end
            end
            DRAIN: begin
               if (exc_valid) begin
                  // The interrupt is dropped here and re-arbitrated once back in IDLE.
                  state      <= FIRE;
                  trap_en    <= 1'b1;
                  trap_cause <= exc_cause_ext;
                  trap_pc    <= exc_pc;
                  trap_mtval <= exc_tval;
               end else if (pipe_empty) begin
                  // Cause was frozen on entry; no re-arbitration while draining.
                  state      <= FIRE;
                  trap_en    <= 1'b1;
                  trap_cause <= irq_cause_lat;
                  trap_pc    <= commit_pc;
               end else begin
                  stall_fetch <= 1'b1;
               end
            end
            FIRE: begin
               // Trap flushes the pipeline, so any exc_valid seen here is stale.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
